rr_arbiter_fsm: RTL and testbench

- Moore-style round-robin arbiter that shares one single-owner resource (e.g. the interpolator datapath or a shared memory port) among N_REQ requesters.
- Built as a registered-output state machine.
- A grant is held for as long as the owner keeps its request high.
- Priority rotates to the requester after the last owner, so no requester starves.

---
 rtl/rr_arbiter_fsm.sv | 213 +++++++++++++++++++++
 tb/tb_rr_arbiter_fsm.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_fsm.sv
// ---------------------------------------------------------------------------
// rr_arbiter_fsm
//
// Moore-style round-robin arbiter sharing one single-owner resource among
// N_REQ requesters. A grant is held for as long as the owner keeps its
// request high (no preemption). On release, the priority pointer moves to
// the requester after the last owner, so no requester can starve. Every
// owner change is separated by exactly one cycle with no grant.
//
// Parameters
//   N_REQ    number of requesters (2..16)
//   IDX_W    width of the grant index, equal to ceil(log2(N_REQ))
//   TMO_CYC  longest grant in cycles before a forced release (>= 2);
//            only meaningful when RRARB_TIMEOUT_EN is defined
//
// Optional feature
//   RRARB_TIMEOUT_EN  when defined, a grant still requested after TMO_CYC
//                     cycles is released as a normal release and tmo_o
//                     pulses for one cycle. When undefined, grants are
//                     unbounded and tmo_o is tied to 0.
//
// Ports
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   req_i      in   [N_REQ] request per requester, held high while in use
//   gnt_o      out  [N_REQ] registered one-hot grant, zero when no owner
//   gnt_vld_o  out  registered, high whenever gnt_o is non-zero
//   gnt_idx_o  out  [IDX_W] registered binary index of the current owner;
//                   keeps its last value while gnt_vld_o is low
//   tmo_o      out  registered one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_fsm #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter int TMO_CYC = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             gnt_vld_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             tmo_o
);

    // Elaboration-time parameter sanity checks.
    if (IDX_W != $clog2(N_REQ)) begin : g_bad_idx_w
        $error("rr_arbiter_fsm: IDX_W must equal ceil(log2(N_REQ))");
    end
    if (TMO_CYC < 2) begin : g_bad_tmo
        $error("rr_arbiter_fsm: TMO_CYC must be at least 2");
    end

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_GRANT   = 2'b01;
    localparam logic [1:0] S_RELEASE = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic             vld_q,   vld_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    logic [IDX_W-1:0] win;
    logic             owner_req;
    logic             tmo_hit;

    // First set request scanning ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1.
    // The wrap is done against N_REQ so non-power-of-2 sizes work.
    function automatic logic [IDX_W-1:0] find_winner(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic             found;
        logic [IDX_W-1:0] sel;
        int               pos;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!found && req[pos]) begin
                found = 1'b1;
                sel   = IDX_W'(pos);
            end
        end
        return sel;
    endfunction

    // (idx + 1) mod N_REQ
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) == N_REQ - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign win       = find_winner(req_i, ptr_q);
    // The grant index register doubles as the owner while in GRANT.
    assign owner_req = req_i[idx_q];

`ifdef RRARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    // Limit reached while the owner still wants the resource. If the owner
    // drops in that same cycle the release is a normal one (no pulse).
    assign tmo_hit = (state_q == S_GRANT) && owner_req &&
                     (cnt_q == CNT_W'(TMO_CYC - 1));

    // Counter is zero in the first GRANT cycle and counts every cycle the
    // grant is held, so a grant lasts at most TMO_CYC cycles.
    always_comb begin
        tmo_d = tmo_hit;
        cnt_d = '0;
        if ((state_q == S_GRANT) && (state_d == S_GRANT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo_o = tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign tmo_o   = 1'b0;
`endif

    // Next state plus the outputs that go with it; outputs are registered
    // from these so they change on the same edge as the state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        case (state_q)
            // RELEASE behaves like IDLE except it always lasts one cycle;
            // ptr has already been rotated on the way in.
            S_IDLE, S_RELEASE: begin
                if (|req_i) begin
                    state_d = S_GRANT;
                    gnt_d   = onehot(win);
                    vld_d   = 1'b1;
                    idx_d   = win;
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                end
            end
            S_GRANT: begin
                if (!owner_req || tmo_hit) begin
                    state_d = S_RELEASE;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    ptr_d   = next_idx(idx_q);
                end
            end
            // Unused code: recover to IDLE with every output cleared.
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                vld_d   = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_vld_o = vld_q;
    assign gnt_idx_o = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_fsm.sv
module tb_rr_arbiter_fsm;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int TMO = 16;
`ifdef RRARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  gnt_o;
    logic          gnt_vld_o;
    logic [IW-1:0] gnt_idx_o;
    logic          tmo_o;

    rr_arbiter_fsm #(.N_REQ(N), .IDX_W(IW), .TMO_CYC(TMO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_i     (req),
        .gnt_o     (gnt_o),
        .gnt_vld_o (gnt_vld_o),
        .gnt_idx_o (gnt_idx_o),
        .tmo_o     (tmo_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int force_req = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The arbiter is either owned (m_owner >= 0) or free. A free arbiter
    // with any request hands the resource to the first requester at or
    // after the pointer; an owner keeps it until it drops its request (or,
    // with the timeout, until it has held it TMO cycles).
    int       m_owner = -1;
    int       m_ptr   = 0;
    int       m_idx   = 0;
    int       m_held  = 0;
    bit       m_tmo   = 1'b0;
    int       force_seen = 0;

    function automatic int search(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_owner    <= -1;
            m_ptr      <= 0;
            m_idx      <= 0;
            m_held     <= 0;
            m_tmo      <= 1'b0;
            force_seen <= force_req;
        end else if (force_seen != force_req) begin
            force_seen <= force_req;
            m_owner    <= -1;
            m_idx      <= 0;
            m_held     <= 0;
            m_tmo      <= 1'b0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner <= -1;
                m_ptr   <= (m_owner + 1) % N;
                m_tmo   <= 1'b0;
            end else if (TMO_ON && m_held == TMO) begin
                m_owner <= -1;
                m_ptr   <= (m_owner + 1) % N;
                m_tmo   <= 1'b1;
            end else begin
                m_held  <= m_held + 1;
                m_tmo   <= 1'b0;
            end
        end else begin
            m_tmo <= 1'b0;
            if (req != '0) begin
                m_owner <= search(req, m_ptr);
                m_idx   <= search(req, m_ptr);
                m_held  <= 1;
            end
        end
    end

    function automatic int exp_gnt();
        return (m_owner >= 0) ? (1 << m_owner) : 0;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_gnt", int'(gnt_o), exp_gnt());
            chk("model_vld", int'(gnt_vld_o), (m_owner >= 0) ? 1 : 0);
            chk("model_idx", int'(gnt_idx_o), m_idx);
            chk("model_tmo", int'(tmo_o), int'(m_tmo));
        end
    end

    // ---------------- stimulus ----------------
    int seq[$];
    int held;
    int n;
    bit done;

    initial begin
        rstn = 1'b0;
        req  = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", int'(gnt_o), 0);
        chk("rst_vld", int'(gnt_vld_o), 0);
        chk("rst_idx", int'(gnt_idx_o), 0);
        chk("rst_tmo", int'(tmo_o), 0);
        rstn   = 1'b1;
        cmp_en = 1'b1;

        // Idle with no requests, then an asynchronous reset mid-grant.
        repeat (5) @(negedge clk);
        chk("idle_gnt", int'(gnt_o), 0);
        req = 4'b0010;
        @(negedge clk);
        chk("pre_rst_gnt", int'(gnt_o), 4'b0010);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_gnt", int'(gnt_o), 0);
        chk("async_rst_vld", int'(gnt_vld_o), 0);
        chk("async_rst_idx", int'(gnt_idx_o), 0);
        @(negedge clk);
        req  = '0;
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // All four request; each owner drops after 2 grant cycles and
        // re-raises one cycle later. Stop once idx 1 owns for the 2nd time.
        held = 0;
        done = 1'b0;
        req  = 4'b1111;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (gnt_vld_o) begin
                if (held == 0) seq.push_back(int'(gnt_idx_o));
                held++;
            end else begin
                held = 0;
            end
            req = 4'b1111;
            if (seq.size() == 6) done = 1'b1;
            else if (gnt_vld_o && held == 2) req[gnt_idx_o] = 1'b0;
        end
        chk("rr_done", int'(done), 1);
        if (seq.size() >= 5) begin
            chk("rr_seq0", seq[0], 0);
            chk("rr_seq1", seq[1], 1);
            chk("rr_seq2", seq[2], 2);
            chk("rr_seq3", seq[3], 3);
            chk("rr_seq4", seq[4], 0);
        end

        // Owner idx 1 with everyone requesting and never releasing.
        if (TMO_ON) begin
            n = 1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (gnt_vld_o && gnt_idx_o == 2'd1) n++;
                else break;
            end
            chk("tmo_len", n, TMO);
            chk("tmo_pulse", int'(tmo_o), 1);
            @(negedge clk);
            chk("tmo_next_idx", int'(gnt_idx_o), 2);
            chk("tmo_pulse_end", int'(tmo_o), 0);
        end else begin
            repeat (40) @(negedge clk);
            chk("hold_idx", int'(gnt_idx_o), 1);
            chk("hold_vld", int'(gnt_vld_o), 1);
            chk("hold_tmo", int'(tmo_o), 0);
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Single requester 2 held for three grant cycles.
        req = 4'b0100;
        @(negedge clk);
        chk("single_gnt", int'(gnt_o), 4'b0100);
        chk("single_idx", int'(gnt_idx_o), 2);
        repeat (2) @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("single_rel_vld", int'(gnt_vld_o), 0);
        chk("single_rel_idx", int'(gnt_idx_o), 2);

        // Wrap: ptr is 3, requests 3 and 0.
        req = 4'b1001;
        @(negedge clk);
        chk("wrap_first", int'(gnt_idx_o), 3);
        req = 4'b0001;
        @(negedge clk);
        chk("wrap_gap", int'(gnt_vld_o), 0);
        req = 4'b1001;
        @(negedge clk);
        chk("wrap_second", int'(gnt_idx_o), 0);
        req = '0;
        repeat (3) @(negedge clk);

        // Illegal state code during a grant.
        req = 4'b0100;
        @(negedge clk);
        force dut.state_q = 2'b11;
        force_req++;
        #1 release dut.state_q;
        @(negedge clk);
        chk("bad_state_gnt", int'(gnt_o), 0);
        chk("bad_state_idx", int'(gnt_idx_o), 0);
        @(negedge clk);
        chk("bad_state_resume", int'(gnt_o), 4'b0100);
        req = '0;
        repeat (3) @(negedge clk);

        // Randomised traffic; patterns held long enough to exercise holds.
        for (int s = 0; s < 120; s++) begin
            req = N'($urandom_range(0, (1 << N) - 1));
            repeat ($urandom_range(1, 24)) @(negedge clk);
        end
        req = '0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
